// File: rtl/ysyx_24100029_axi_arbiter.sv
// Two-master AXI4 arbiter: IFU (m0, read-only) and LSU (m1, read/write) share one slave port,
// one whole transaction at a time, round-robin, with a sticky watchdog flag for hung slaves.
module ysyx_24100029_axi_arbiter #(
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_arvalid,
  output logic        m0_arready,
  input  logic [31:0] m0_araddr,
  input  logic [3:0]  m0_arid,
  input  logic [7:0]  m0_arlen,
  input  logic [2:0]  m0_arsize,
  input  logic [1:0]  m0_arburst,
  output logic        m0_rvalid,
  input  logic        m0_rready,
  output logic [1:0]  m0_rresp,
  output logic [31:0] m0_rdata,
  output logic        m0_rlast,
  output logic [3:0]  m0_rid,
  input  logic        m1_arvalid,
  output logic        m1_arready,
  input  logic [31:0] m1_araddr,
  input  logic [3:0]  m1_arid,
  input  logic [7:0]  m1_arlen,
  input  logic [2:0]  m1_arsize,
  input  logic [1:0]  m1_arburst,
  output logic        m1_rvalid,
  input  logic        m1_rready,
  output logic [1:0]  m1_rresp,
  output logic [31:0] m1_rdata,
  output logic        m1_rlast,
  output logic [3:0]  m1_rid,
  input  logic        m1_awvalid,
  output logic        m1_awready,
  input  logic [31:0] m1_awaddr,
  input  logic [3:0]  m1_awid,
  input  logic [7:0]  m1_awlen,
  input  logic [2:0]  m1_awsize,
  input  logic [1:0]  m1_awburst,
  input  logic        m1_wvalid,
  output logic        m1_wready,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  input  logic        m1_wlast,
  output logic        m1_bvalid,
  input  logic        m1_bready,
  output logic [1:0]  m1_bresp,
  output logic [3:0]  m1_bid,
  output logic        s_arvalid,
  input  logic        s_arready,
  output logic [31:0] s_araddr,
  output logic [3:0]  s_arid,
  output logic [7:0]  s_arlen,
  output logic [2:0]  s_arsize,
  output logic [1:0]  s_arburst,
  input  logic        s_rvalid,
  output logic        s_rready,
  input  logic [1:0]  s_rresp,
  input  logic [31:0] s_rdata,
  input  logic        s_rlast,
  input  logic [3:0]  s_rid,
  output logic        s_awvalid,
  input  logic        s_awready,
  output logic [31:0] s_awaddr,
  output logic [3:0]  s_awid,
  output logic [7:0]  s_awlen,
  output logic [2:0]  s_awsize,
  output logic [1:0]  s_awburst,
  output logic        s_wvalid,
  input  logic        s_wready,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  output logic        s_wlast,
  input  logic        s_bvalid,
  output logic        s_bready,
  input  logic [1:0]  s_bresp,
  input  logic [3:0]  s_bid,
  output logic        grant_lsu,
  output logic        err_timeout
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_IFU_RD = 2'd1;
  localparam logic [1:0] S_LSU_RD = 2'd2;
  localparam logic [1:0] S_LSU_WR = 2'd3;
  localparam logic [CNT_W-1:0] L_TIMEOUT = CNT_W'(TIMEOUT);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [1:0]       w_lsu_pick;
  logic             r_last_lsu;
  logic             r_ar_done;
  logic             r_aw_done;
  logic [CNT_W-1:0] r_wdt_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_err;
  logic             w_req0;
  logic             w_req1;

  assign w_req0     = m0_arvalid;
  assign w_req1     = m1_awvalid | m1_arvalid;
  assign w_lsu_pick = m1_awvalid ? S_LSU_WR : S_LSU_RD;
  assign w_cnt_inc  = (r_wdt_cnt == {CNT_W{1'b1}}) ? r_wdt_cnt : r_wdt_cnt + CNT_W'(1);
  assign grant_lsu  = (r_state == S_LSU_RD) || (r_state == S_LSU_WR);
  assign err_timeout = r_err;

  // Next-state: arbitration in IDLE, completion detection in granted states.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req0 && w_req1) begin
          w_state_nxt = r_last_lsu ? S_IFU_RD : w_lsu_pick;
        end else if (w_req0) begin
          w_state_nxt = S_IFU_RD;
        end else if (w_req1) begin
          w_state_nxt = w_lsu_pick;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_IFU_RD, S_LSU_RD: begin
        if (s_rvalid && s_rready && s_rlast) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_LSU_WR: begin
        if (s_bvalid && s_bready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, round-robin pointer and one-shot address-issue flags.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_last_lsu <= 1'b1;
      r_ar_done  <= 1'b0;
      r_aw_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_IDLE) && (w_state_nxt != S_IDLE)) begin
        r_last_lsu <= (w_state_nxt != S_IFU_RD);
      end
      if (r_state == S_IDLE) begin
        r_ar_done <= 1'b0;
        r_aw_done <= 1'b0;
      end else begin
        if (s_arvalid && s_arready) r_ar_done <= 1'b1;
        if (s_awvalid && s_awready) r_aw_done <= 1'b1;
      end
    end
  end

  // Watchdog: counts granted cycles; the error flag is sticky until reset and never forces release.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wdt_cnt <= {CNT_W{1'b0}};
      r_err     <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_wdt_cnt <= {CNT_W{1'b0}};
    end else begin
      r_wdt_cnt <= w_cnt_inc;
      if ((L_TIMEOUT != {CNT_W{1'b0}}) && (w_cnt_inc == L_TIMEOUT)) r_err <= 1'b1;
    end
  end

  // Routing: only the owner is connected; everything else reads as zero.
  always_comb begin
    m0_arready = 1'b0;  m0_rvalid = 1'b0;  m0_rresp = 2'b00;
    m0_rdata   = 32'h0; m0_rlast  = 1'b0;  m0_rid   = 4'h0;
    m1_arready = 1'b0;  m1_rvalid = 1'b0;  m1_rresp = 2'b00;
    m1_rdata   = 32'h0; m1_rlast  = 1'b0;  m1_rid   = 4'h0;
    m1_awready = 1'b0;  m1_wready = 1'b0;
    m1_bvalid  = 1'b0;  m1_bresp  = 2'b00; m1_bid   = 4'h0;
    s_arvalid  = 1'b0;  s_araddr  = 32'h0; s_arid   = 4'h0;
    s_arlen    = 8'h0;  s_arsize  = 3'b000; s_arburst = 2'b00;
    s_rready   = 1'b0;
    s_awvalid  = 1'b0;  s_awaddr  = 32'h0; s_awid   = 4'h0;
    s_awlen    = 8'h0;  s_awsize  = 3'b000; s_awburst = 2'b00;
    s_wvalid   = 1'b0;  s_wdata   = 32'h0; s_wstrb  = 4'h0; s_wlast = 1'b0;
    s_bready   = 1'b0;
    case (r_state)
      S_IFU_RD: begin
        s_arvalid  = m0_arvalid & ~r_ar_done;
        m0_arready = s_arready & ~r_ar_done;
        s_araddr   = m0_araddr;  s_arid    = m0_arid;   s_arlen = m0_arlen;
        s_arsize   = m0_arsize;  s_arburst = m0_arburst;
        m0_rvalid  = s_rvalid;   s_rready  = m0_rready;
        m0_rresp   = s_rresp;    m0_rdata  = s_rdata;   m0_rlast = s_rlast; m0_rid = s_rid;
      end
      S_LSU_RD: begin
        s_arvalid  = m1_arvalid & ~r_ar_done;
        m1_arready = s_arready & ~r_ar_done;
        s_araddr   = m1_araddr;  s_arid    = m1_arid;   s_arlen = m1_arlen;
        s_arsize   = m1_arsize;  s_arburst = m1_arburst;
        m1_rvalid  = s_rvalid;   s_rready  = m1_rready;
        m1_rresp   = s_rresp;    m1_rdata  = s_rdata;   m1_rlast = s_rlast; m1_rid = s_rid;
      end
      S_LSU_WR: begin
        // W is open from entry so a master may present data before its address.
        s_awvalid  = m1_awvalid & ~r_aw_done;
        m1_awready = s_awready & ~r_aw_done;
        s_awaddr   = m1_awaddr;  s_awid    = m1_awid;   s_awlen = m1_awlen;
        s_awsize   = m1_awsize;  s_awburst = m1_awburst;
        s_wvalid   = m1_wvalid;  m1_wready = s_wready;
        s_wdata    = m1_wdata;   s_wstrb   = m1_wstrb;  s_wlast = m1_wlast;
        m1_bvalid  = s_bvalid;   s_bready  = m1_bready;
        m1_bresp   = s_bresp;    m1_bid    = s_bid;
      end
      default: begin
      end
    endcase
  end

endmodule
